// File: rtl/tmr_pkg.sv
// Shared FSM state type and default sizing for the triple-modular-redundancy
// vote controller.
package tmr_pkg;

  localparam int DEF_WIDTH   = 8;
  localparam int DEF_TIMEOUT = 16;
  localparam int DEF_CNT_W   = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    VOTE    = 2'd2,
    OUTPUT  = 2'd3
  } state_t;

endpackage

// File: rtl/majority_voter.sv
// Single-bit two-out-of-three majority voter.
module majority_voter (
  input  logic A,
  input  logic B,
  input  logic C,
  output logic OUT
);

  assign OUT = (A & B) | (A & C) | (B & C);

endmodule

// File: rtl/tmr_vote_controller.sv
// Collects three replica results, votes on them bitwise or with a timeout-driven
// fallback, and keeps saturating per-replica fault counters.
module tmr_vote_controller
  import tmr_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             VALID_A,
  input  logic             VALID_B,
  input  logic             VALID_C,
  input  logic [WIDTH-1:0] DATA_A,
  input  logic [WIDTH-1:0] DATA_B,
  input  logic [WIDTH-1:0] DATA_C,
  output logic             READY_A,
  output logic             READY_B,
  output logic             READY_C,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] OUT_DATA,
  output logic             MISMATCH,
  output logic             DEGRADED,
  output logic             ERROR,
  input  logic             CLR_CNT,
  output logic [CNT_W-1:0] FAULT_CNT_A,
  output logic [CNT_W-1:0] FAULT_CNT_B,
  output logic [CNT_W-1:0] FAULT_CNT_C
);

  localparam int               TCW     = $clog2(TIMEOUT + 1);
  localparam logic [TCW-1:0]   T_LAST  = TCW'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t                  state_r;
  logic [2:0]              cap_r;
  logic [2:0][WIDTH-1:0]   data_r;
  logic [TCW-1:0]          tcnt_r;
  logic                    timeout_r;
  logic                    out_valid_r;
  logic [WIDTH-1:0]        out_data_r;
  logic                    mismatch_r;
  logic                    degraded_r;
  logic                    error_r;
  logic [2:0][CNT_W-1:0]   cnt_r;

  logic [2:0]              valid_s;
  logic [2:0]              ready_s;
  logic [2:0]              capture_s;
  logic [2:0]              diff_s;
  logic [2:0]              fault_s;
  logic [2:0][WIDTH-1:0]   din_s;
  logic [WIDTH-1:0]        maj_s;
  logic [WIDTH-1:0]        pair_word_s;
  logic [WIDTH-1:0]        vote_data_s;
  logic                    pair_eq_s;
  logic                    vote_deg_s;
  logic                    vote_err_s;
  logic                    all_s;
  logic                    accepting_s;

  assign valid_s     = {VALID_C, VALID_B, VALID_A};
  assign din_s       = {DATA_C, DATA_B, DATA_A};
  assign accepting_s = (state_r == IDLE) || (state_r == COLLECT);
  assign ready_s     = accepting_s ? ~cap_r : 3'b000;
  assign capture_s   = valid_s & ready_s;
  assign all_s       = &(cap_r | capture_s);

  assign {READY_C, READY_B, READY_A} = ready_s;
  assign OUT_VALID   = out_valid_r;
  assign OUT_DATA    = out_data_r;
  assign MISMATCH    = mismatch_r;
  assign DEGRADED    = degraded_r;
  assign ERROR       = error_r;
  assign FAULT_CNT_A = cnt_r[0];
  assign FAULT_CNT_B = cnt_r[1];
  assign FAULT_CNT_C = cnt_r[2];

  for (genvar i = 0; i < WIDTH; i++) begin : g_vote
    majority_voter u_maj (
      .A   (data_r[0][i]),
      .B   (data_r[1][i]),
      .C   (data_r[2][i]),
      .OUT (maj_s[i])
    );
  end

  // Vote result: full majority, or on timeout the agreeing pair, else a zero error word.
  always_comb begin
    pair_eq_s   = 1'b0;
    pair_word_s = '0;
    vote_data_s = '0;
    vote_deg_s  = 1'b0;
    vote_err_s  = 1'b0;
    diff_s      = 3'b000;
    fault_s     = 3'b000;
    case (cap_r)
      3'b011: begin
        pair_eq_s   = (data_r[0] == data_r[1]);
        pair_word_s = data_r[0];
      end
      3'b101: begin
        pair_eq_s   = (data_r[0] == data_r[2]);
        pair_word_s = data_r[0];
      end
      3'b110: begin
        pair_eq_s   = (data_r[1] == data_r[2]);
        pair_word_s = data_r[1];
      end
      default: begin
        pair_eq_s   = 1'b0;
        pair_word_s = '0;
      end
    endcase
    if (!timeout_r) begin
      vote_data_s = maj_s;
    end else if (pair_eq_s) begin
      vote_data_s = pair_word_s;
      vote_deg_s  = 1'b1;
    end else begin
      vote_data_s = '0;
      vote_err_s  = 1'b1;
    end
    for (int i = 0; i < 3; i++) begin
      diff_s[i]  = cap_r[i] && (data_r[i] != vote_data_s);
      fault_s[i] = diff_s[i] || (!cap_r[i] && timeout_r);
    end
  end

  // Controller FSM with capture registers, registered vote outputs and fault counters.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r     <= IDLE;
      cap_r       <= 3'b000;
      data_r      <= '0;
      tcnt_r      <= '0;
      timeout_r   <= 1'b0;
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      mismatch_r  <= 1'b0;
      degraded_r  <= 1'b0;
      error_r     <= 1'b0;
      cnt_r       <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (capture_s[i]) begin
          cap_r[i]  <= 1'b1;
          data_r[i] <= din_s[i];
        end
      end
      case (state_r)
        IDLE: begin
          if (|capture_s) begin
            tcnt_r    <= '0;
            timeout_r <= 1'b0;
            state_r   <= all_s ? VOTE : COLLECT;
          end
        end
        COLLECT: begin
          // A final capture on the timeout cycle wins over the timeout.
          if (all_s) begin
            state_r <= VOTE;
          end else if (tcnt_r == T_LAST) begin
            state_r   <= VOTE;
            timeout_r <= 1'b1;
          end else begin
            tcnt_r <= tcnt_r + TCW'(1);
          end
        end
        VOTE: begin
          out_data_r  <= vote_data_s;
          mismatch_r  <= |diff_s;
          degraded_r  <= vote_deg_s;
          error_r     <= vote_err_s;
          out_valid_r <= 1'b1;
          state_r     <= OUTPUT;
        end
        OUTPUT: begin
          if (OUT_READY) begin
            state_r     <= IDLE;
            out_valid_r <= 1'b0;
            cap_r       <= 3'b000;
            timeout_r   <= 1'b0;
            mismatch_r  <= 1'b0;
            degraded_r  <= 1'b0;
            error_r     <= 1'b0;
          end
        end
        default: state_r <= IDLE;
      endcase
      if (CLR_CNT) begin
        cnt_r <= '0;
      end else if (state_r == VOTE) begin
        for (int i = 0; i < 3; i++) begin
          if (fault_s[i] && (cnt_r[i] != CNT_MAX)) begin
            cnt_r[i] <= cnt_r[i] + CNT_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_tmr_vote_controller.sv
// Self-checking bench for tmr_vote_controller: directed scenarios plus randomized
// transactions compared against an arrival-time based reference model.
module tb_tmr_vote_controller;

  localparam int WIDTH   = 8;
  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 8;
  localparam int MAXC    = 80;

  logic             CLK = 1'b0;
  logic             RST;
  logic             VALID_A, VALID_B, VALID_C;
  logic [WIDTH-1:0] DATA_A, DATA_B, DATA_C;
  logic             READY_A, READY_B, READY_C;
  logic             OUT_VALID;
  logic             OUT_READY;
  logic [WIDTH-1:0] OUT_DATA;
  logic             MISMATCH, DEGRADED, ERROR;
  logic             CLR_CNT;
  logic [CNT_W-1:0] FAULT_CNT_A, FAULT_CNT_B, FAULT_CNT_C;
  logic [2:0]       rdy;

  int checks = 0;
  int errors = 0;

  // Transaction description: arrival cycle per replica (-1 = never) and its word.
  int         t_arr[3];
  logic [7:0] d_arr[3];
  int         model_cnt[3];

  logic [7:0] exp_data;
  logic       exp_mis, exp_deg, exp_err;
  int         exp_cycle;

  int         obs_cycle;
  logic [7:0] obs_data;
  logic       obs_mis, obs_deg, obs_err;
  int         obs_unstable;
  logic [2:0] obs_ready_after;
  logic       obs_after_valid;
  logic [2:0] obs_after_flags;

  always #5 CLK = ~CLK;

  assign rdy = {READY_C, READY_B, READY_A};

  tmr_vote_controller #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST(RST),
    .VALID_A(VALID_A), .VALID_B(VALID_B), .VALID_C(VALID_C),
    .DATA_A(DATA_A), .DATA_B(DATA_B), .DATA_C(DATA_C),
    .READY_A(READY_A), .READY_B(READY_B), .READY_C(READY_C),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_DATA(OUT_DATA),
    .MISMATCH(MISMATCH), .DEGRADED(DEGRADED), .ERROR(ERROR),
    .CLR_CNT(CLR_CNT),
    .FAULT_CNT_A(FAULT_CNT_A), .FAULT_CNT_B(FAULT_CNT_B), .FAULT_CNT_C(FAULT_CNT_C)
  );

  // Reference model: derives the outcome from arrival times and the voting rules.
  task automatic model_txn();
    int f = 1000;
    int last = -1;
    bit all_in = 1'b1;
    bit tmo;
    logic [2:0] cap;
    int dl, ones, i0, i1;
    for (int i = 0; i < 3; i++) begin
      if (t_arr[i] < 0) all_in = 1'b0;
      else begin
        if (t_arr[i] < f) f = t_arr[i];
        if (t_arr[i] > last) last = t_arr[i];
      end
    end
    dl = f + TIMEOUT;
    tmo = !(all_in && (last <= dl));
    exp_cycle = tmo ? dl + 2 : last + 2;
    for (int i = 0; i < 3; i++) cap[i] = (t_arr[i] >= 0) && (t_arr[i] <= dl);
    exp_data = 8'h00; exp_deg = 1'b0; exp_err = 1'b0;
    if (!tmo) begin
      for (int b = 0; b < 8; b++) begin
        ones = int'(d_arr[0][b]) + int'(d_arr[1][b]) + int'(d_arr[2][b]);
        exp_data[b] = (ones >= 2);
      end
    end else if ($countones(cap) == 2) begin
      i0 = -1; i1 = -1;
      for (int i = 0; i < 3; i++) if (cap[i]) begin if (i0 < 0) i0 = i; else i1 = i; end
      if (d_arr[i0] == d_arr[i1]) begin exp_data = d_arr[i0]; exp_deg = 1'b1; end
      else exp_err = 1'b1;
    end else begin
      exp_err = 1'b1;
    end
    exp_mis = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (cap[i] && (d_arr[i] != exp_data)) exp_mis = 1'b1;
      if (((cap[i] && (d_arr[i] != exp_data)) || !cap[i]) && (model_cnt[i] < 255))
        model_cnt[i]++;
    end
  endtask

  // Drives one transaction, records what the DUT produced and completes the handshake.
  task automatic drive_txn(input int hold);
    logic [2:0] v;
    logic [7:0] d[3];
    bit seen = 1'b0;
    int c = 0;
    obs_cycle = -1; obs_unstable = 0; obs_ready_after = 3'b111;
    while (!seen && (c < MAXC)) begin
      @(negedge CLK);
      if (OUT_VALID === 1'b1) begin
        seen = 1'b1;
        obs_cycle = c; obs_data = OUT_DATA;
        obs_mis = MISMATCH; obs_deg = DEGRADED; obs_err = ERROR;
        {VALID_C, VALID_B, VALID_A} = 3'b000;
        OUT_READY = (hold == 0);
      end else begin
        for (int i = 0; i < 3; i++) begin
          if ((t_arr[i] >= 0) && (c == t_arr[i] + 1)) obs_ready_after[i] = rdy[i];
          v[i] = (t_arr[i] >= 0) && (c >= t_arr[i]);
          d[i] = (c == t_arr[i]) ? d_arr[i] : 8'($urandom);
        end
        {VALID_C, VALID_B, VALID_A} = v;
        DATA_A = d[0]; DATA_B = d[1]; DATA_C = d[2];
        c++;
      end
    end
    {VALID_C, VALID_B, VALID_A} = 3'b000;
    if (seen) begin
      for (int h = 1; h <= hold; h++) begin
        @(negedge CLK);
        if ((OUT_VALID !== 1'b1) || (OUT_DATA !== obs_data) || (MISMATCH !== obs_mis) ||
            (DEGRADED !== obs_deg) || (ERROR !== obs_err)) obs_unstable++;
        if (h == hold) OUT_READY = 1'b1;
      end
      @(negedge CLK);
      OUT_READY = 1'b0;
    end
    obs_after_valid = OUT_VALID;
    obs_after_flags = {MISMATCH, DEGRADED, ERROR};
  endtask

  task automatic test_reset();
    RST = 1'b1; OUT_READY = 1'b0; CLR_CNT = 1'b0;
    {VALID_C, VALID_B, VALID_A} = 3'b000;
    DATA_A = 8'h00; DATA_B = 8'h00; DATA_C = 8'h00;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    checks++;
    if ({OUT_VALID, OUT_DATA, MISMATCH, DEGRADED, ERROR} !== 12'h000) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b data=%h mis=%b deg=%b err=%b, expected all 0",
               OUT_VALID, OUT_DATA, MISMATCH, DEGRADED, ERROR);
    end
    checks++;
    if ({FAULT_CNT_A, FAULT_CNT_B, FAULT_CNT_C} !== 24'h000000) begin
      errors++;
      $display("FAIL reset_counters: got %0d/%0d/%0d, expected 0/0/0",
               FAULT_CNT_A, FAULT_CNT_B, FAULT_CNT_C);
    end
    checks++;
    if (rdy !== 3'b111) begin
      errors++;
      $display("FAIL reset_ready: got %b, expected 111", rdy);
    end
    for (int i = 0; i < 3; i++) model_cnt[i] = 0;
  endtask

  task automatic test_all_same();
    t_arr = '{0, 0, 0}; d_arr = '{8'h5A, 8'h5A, 8'h5A};
    model_txn(); drive_txn(0);
    checks++;
    if (obs_cycle != 2) begin
      errors++; $display("FAIL all_same_latency: got cycle %0d, expected 2", obs_cycle);
    end
    checks++;
    if ({obs_data, obs_mis, obs_deg, obs_err} !== {8'h5A, 3'b000}) begin
      errors++;
      $display("FAIL all_same_result: got data=%h mis=%b deg=%b err=%b, expected data=5a mis=0 deg=0 err=0",
               obs_data, obs_mis, obs_deg, obs_err);
    end
    checks++;
    if ({FAULT_CNT_A, FAULT_CNT_B, FAULT_CNT_C} !== 24'h000000) begin
      errors++;
      $display("FAIL all_same_counters: got %0d/%0d/%0d, expected 0/0/0",
               FAULT_CNT_A, FAULT_CNT_B, FAULT_CNT_C);
    end
    checks++;
    if ({obs_after_valid, obs_after_flags} !== 4'b0000) begin
      errors++;
      $display("FAIL all_same_release: got valid=%b flags=%b, expected 0 000",
               obs_after_valid, obs_after_flags);
    end
  endtask

  task automatic test_staggered();
    t_arr = '{0, 2, 4}; d_arr = '{8'hF0, 8'hF0, 8'h0F};
    model_txn(); drive_txn(0);
    checks++;
    if (obs_cycle != exp_cycle) begin
      errors++; $display("FAIL staggered_latency: got cycle %0d, expected %0d", obs_cycle, exp_cycle);
    end
    checks++;
    if ({obs_data, obs_mis, obs_deg, obs_err} !== {8'hF0, 3'b100}) begin
      errors++;
      $display("FAIL staggered_result: got data=%h mis=%b deg=%b err=%b, expected data=f0 mis=1 deg=0 err=0",
               obs_data, obs_mis, obs_deg, obs_err);
    end
    checks++;
    if (obs_ready_after[0] !== 1'b0) begin
      errors++; $display("FAIL staggered_ready_a: got %b after capture, expected 0", obs_ready_after[0]);
    end
    checks++;
    if ({FAULT_CNT_A, FAULT_CNT_B, FAULT_CNT_C} !== {8'd0, 8'd0, 8'd1}) begin
      errors++;
      $display("FAIL staggered_counters: got %0d/%0d/%0d, expected 0/0/1",
               FAULT_CNT_A, FAULT_CNT_B, FAULT_CNT_C);
    end
  endtask

  // Two replicas early; C never, on the final COLLECT cycle, or one cycle too late.
  task automatic test_degraded();
    int tc[3] = '{-1, 16, 17};
    for (int k = 0; k < 3; k++) begin
      t_arr = '{0, 0, tc[k]}; d_arr = '{8'h33, 8'h33, 8'h33};
      model_txn(); drive_txn(0);
      checks++;
      if (obs_cycle != exp_cycle) begin
        errors++;
        $display("FAIL degraded_latency[%0d]: got cycle %0d, expected %0d", k, obs_cycle, exp_cycle);
      end
      checks++;
      if ({obs_data, obs_mis, obs_deg, obs_err} !== {exp_data, exp_mis, exp_deg, exp_err}) begin
        errors++;
        $display("FAIL degraded_result[%0d]: got data=%h mis=%b deg=%b err=%b, expected data=%h mis=%b deg=%b err=%b",
                 k, obs_data, obs_mis, obs_deg, obs_err, exp_data, exp_mis, exp_deg, exp_err);
      end
      checks++;
      if ({FAULT_CNT_A, FAULT_CNT_B, FAULT_CNT_C} !==
          {8'(model_cnt[0]), 8'(model_cnt[1]), 8'(model_cnt[2])}) begin
        errors++;
        $display("FAIL degraded_counters[%0d]: got %0d/%0d/%0d, expected %0d/%0d/%0d", k,
                 FAULT_CNT_A, FAULT_CNT_B, FAULT_CNT_C, model_cnt[0], model_cnt[1], model_cnt[2]);
      end
    end
  endtask

  task automatic test_error();
    for (int k = 0; k < 2; k++) begin
      if (k == 0) begin t_arr = '{0, -1, -1}; d_arr = '{8'h5C, 8'h00, 8'h00}; end
      else begin t_arr = '{0, 3, -1}; d_arr = '{8'h12, 8'h34, 8'h00}; end
      model_txn(); drive_txn(1);
      checks++;
      if ({obs_data, obs_err, obs_deg} !== {8'h00, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL error_result[%0d]: got data=%h err=%b deg=%b, expected data=00 err=1 deg=0",
                 k, obs_data, obs_err, obs_deg);
      end
      checks++;
      if ((obs_cycle != exp_cycle) || (obs_mis !== exp_mis)) begin
        errors++;
        $display("FAIL error_timing[%0d]: got cycle=%0d mis=%b, expected cycle=%0d mis=%b",
                 k, obs_cycle, obs_mis, exp_cycle, exp_mis);
      end
      checks++;
      if ({FAULT_CNT_A, FAULT_CNT_B, FAULT_CNT_C} !==
          {8'(model_cnt[0]), 8'(model_cnt[1]), 8'(model_cnt[2])}) begin
        errors++;
        $display("FAIL error_counters[%0d]: got %0d/%0d/%0d, expected %0d/%0d/%0d", k,
                 FAULT_CNT_A, FAULT_CNT_B, FAULT_CNT_C, model_cnt[0], model_cnt[1], model_cnt[2]);
      end
    end
  endtask

  task automatic test_backpressure();
    t_arr = '{0, 0, 0}; d_arr = '{8'hA5, 8'h3C, 8'hA4};
    model_txn(); drive_txn(5);
    checks++;
    if (obs_unstable != 0) begin
      errors++; $display("FAIL backpressure_hold: got %0d unstable cycles, expected 0", obs_unstable);
    end
    checks++;
    if ({obs_data, obs_mis} !== {exp_data, exp_mis}) begin
      errors++;
      $display("FAIL backpressure_result: got data=%h mis=%b, expected data=%h mis=%b",
               obs_data, obs_mis, exp_data, exp_mis);
    end
    checks++;
    if ({obs_after_valid, obs_after_flags} !== 4'b0000) begin
      errors++;
      $display("FAIL backpressure_release: got valid=%b flags=%b, expected 0 000",
               obs_after_valid, obs_after_flags);
    end
  endtask

  task automatic test_random();
    logic [7:0] base;
    for (int n = 0; n < 40; n++) begin
      base = 8'($urandom);
      for (int i = 0; i < 3; i++) begin
        case ($urandom_range(0, 9))
          0:       t_arr[i] = -1;
          1:       t_arr[i] = int'($urandom_range(18, 26));
          default: t_arr[i] = int'($urandom_range(0, 6));
        endcase
        case ($urandom_range(0, 3))
          0, 1:    d_arr[i] = base;
          2:       d_arr[i] = base ^ (8'd1 << $urandom_range(0, 7));
          default: d_arr[i] = 8'($urandom);
        endcase
      end
      if ((t_arr[0] < 0) && (t_arr[1] < 0) && (t_arr[2] < 0)) t_arr[0] = 0;
      model_txn(); drive_txn(int'($urandom_range(0, 3)));
      checks++;
      if ((obs_cycle != exp_cycle) || (obs_unstable != 0) ||
          ({obs_data, obs_mis, obs_deg, obs_err} !== {exp_data, exp_mis, exp_deg, exp_err})) begin
        errors++;
        $display("FAIL random_result[%0d]: got cyc=%0d data=%h mis=%b deg=%b err=%b unstable=%0d, expected cyc=%0d data=%h mis=%b deg=%b err=%b",
                 n, obs_cycle, obs_data, obs_mis, obs_deg, obs_err, obs_unstable,
                 exp_cycle, exp_data, exp_mis, exp_deg, exp_err);
      end
      checks++;
      if ({FAULT_CNT_A, FAULT_CNT_B, FAULT_CNT_C} !==
          {8'(model_cnt[0]), 8'(model_cnt[1]), 8'(model_cnt[2])}) begin
        errors++;
        $display("FAIL random_counters[%0d]: got %0d/%0d/%0d, expected %0d/%0d/%0d", n,
                 FAULT_CNT_A, FAULT_CNT_B, FAULT_CNT_C, model_cnt[0], model_cnt[1], model_cnt[2]);
      end
    end
  endtask

  task automatic test_reset_mid();
    @(negedge CLK);
    VALID_A = 1'b1; DATA_A = 8'hAA;
    @(negedge CLK);
    VALID_A = 1'b0;
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    checks++;
    if ({rdy, OUT_VALID, OUT_DATA, MISMATCH, DEGRADED, ERROR, FAULT_CNT_A, FAULT_CNT_B, FAULT_CNT_C} !==
        {3'b111, 12'h000, 24'h000000}) begin
      errors++;
      $display("FAIL reset_mid_state: got rdy=%b valid=%b data=%h cnt=%0d/%0d/%0d, expected rdy=111 and all 0",
               rdy, OUT_VALID, OUT_DATA, FAULT_CNT_A, FAULT_CNT_B, FAULT_CNT_C);
    end
    for (int i = 0; i < 3; i++) model_cnt[i] = 0;
    t_arr = '{2, 0, 0}; d_arr = '{8'h11, 8'h22, 8'h44};
    model_txn(); drive_txn(1);
    checks++;
    if ((obs_cycle != exp_cycle) || ({obs_data, obs_mis} !== {exp_data, exp_mis})) begin
      errors++;
      $display("FAIL reset_mid_txn: got cyc=%0d data=%h mis=%b, expected cyc=%0d data=%h mis=%b",
               obs_cycle, obs_data, obs_mis, exp_cycle, exp_data, exp_mis);
    end
  endtask

  task automatic test_saturate();
    logic [7:0] x;
    for (int n = 0; n < 300; n++) begin
      x = 8'($urandom);
      t_arr = '{0, 0, 0}; d_arr = '{x, x, ~x};
      model_txn(); drive_txn(0);
    end
    checks++;
    if ({FAULT_CNT_A, FAULT_CNT_B, FAULT_CNT_C} !== {8'd1, 8'd1, 8'd255}) begin
      errors++;
      $display("FAIL saturate_counters: got %0d/%0d/%0d, expected 1/1/255",
               FAULT_CNT_A, FAULT_CNT_B, FAULT_CNT_C);
    end
    // Clear held across a faulting vote must win over the increment.
    CLR_CNT = 1'b1;
    t_arr = '{0, 0, 0}; d_arr = '{8'h01, 8'h01, 8'h80};
    model_txn(); drive_txn(0);
    for (int i = 0; i < 3; i++) model_cnt[i] = 0;
    CLR_CNT = 1'b0;
    checks++;
    if ({FAULT_CNT_A, FAULT_CNT_B, FAULT_CNT_C} !== 24'h000000) begin
      errors++;
      $display("FAIL clear_priority: got %0d/%0d/%0d, expected 0/0/0",
               FAULT_CNT_A, FAULT_CNT_B, FAULT_CNT_C);
    end
    model_txn(); drive_txn(0);
    checks++;
    if ({FAULT_CNT_A, FAULT_CNT_B, FAULT_CNT_C} !== {8'd0, 8'd0, 8'd1}) begin
      errors++;
      $display("FAIL count_after_clear: got %0d/%0d/%0d, expected 0/0/1",
               FAULT_CNT_A, FAULT_CNT_B, FAULT_CNT_C);
    end
  endtask

  initial begin
    test_reset();
    test_all_same();
    test_staggered();
    test_degraded();
    test_error();
    test_backpressure();
    test_random();
    test_reset_mid();
    test_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
